// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access path: size codes,
// controller state encoding and the alignment rule.
package dm_pkg;

  localparam int DM_AW_DEF = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Reserved size code (2'b11) is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      SZ_WORD: is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// Byte/halfword lane handling for 32-bit memory words: extracts and
// extends a load lane, and merges store data into a fetched word.
module dm_lane_mux
  import dm_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [1:0]  byte_off;
  logic [4:0]  sh;
  logic [31:0] lane_word;
  logic [31:0] ins_mask;
  logic [31:0] ins_data;

  // Bit offset of the addressed lane, then extract/extend and merge.
  always_comb begin
    byte_off  = 2'b00;
    load_data = 32'h0;
    ins_mask  = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: byte_off = BIG_ENDIAN ? ~lo : lo;
      SZ_HALF: byte_off = BIG_ENDIAN ? {~lo[1], 1'b0} : {lo[1], 1'b0};
      default: byte_off = 2'b00;
    endcase
    sh        = {byte_off, 3'b000};
    lane_word = word >> sh;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sext & lane_word[7]}}, lane_word[7:0]};
        ins_mask  = 32'h0000_00FF;
      end
      SZ_HALF: begin
        load_data = {{16{sext & lane_word[15]}}, lane_word[15:0]};
        ins_mask  = 32'h0000_FFFF;
      end
      default: begin
        load_data = lane_word;
        ins_mask  = 32'hFFFF_FFFF;
      end
    endcase
    ins_mask = ins_mask << sh;
    ins_data = (wdata << sh) & ins_mask;
    merged   = (word & ~ins_mask) | ins_data;
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage initiator for the word-organised data memory. Loads take one
// read cycle; byte/half stores are read-modify-write; word stores write
// directly.
//
// Handshake: req is looked at only while IDLE (busy=0). An aligned request
// is accepted on that edge, busy rises the next cycle and stays high through
// the single-cycle done pulse; req while busy is dropped, not queued. A
// misaligned request is refused with a one-cycle err pulse and no strobes.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int DM_AW      = DM_AW_DEF,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             sext,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             busy,
  output logic             done,
  output logic [31:0]      rdata,
  output logic             err,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_wr,
  output logic             dm_rd,
  input  logic [31:0]      dm_dout
);

  state_t           state_q;
  state_t           state_d;
  logic [DM_AW+1:0] addr_q;
  logic             we_q;
  logic             sext_q;
  logic [1:0]       size_q;
  logic             req_idle;
  logic             reject;
  logic             accept;
  logic [31:0]      load_data;
  logic [31:0]      merged;
  logic             unused_addr_bits;

  // Upper address bits lie outside the 4 KB window and are ignored.
  assign unused_addr_bits = ^addr[31:DM_AW+2];

  assign req_idle = req && (state_q == S_IDLE);
  assign reject   = req_idle && is_misaligned(size, addr[1:0]);
  assign accept   = req_idle && !reject;
  assign dm_addr  = addr_q[DM_AW+1:2];

  // dm_din doubles as the store-data holder so the merge reads it directly.
  dm_lane_mux #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_mux (
    .word      (dm_dout),
    .lo        (addr_q[1:0]),
    .size      (size_q),
    .sext      (sext_q),
    .wdata     (dm_din),
    .load_data (load_data),
    .merged    (merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and strobe decode; strobes come straight from the state.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    dm_rd   = 1'b0;
    dm_wr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (we && size == SZ_WORD) ? S_WR : S_RD;
      end
      S_RD: begin
        busy    = 1'b1;
        dm_rd   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        state_d = we_q ? S_WR : S_DONE;
      end
      S_WR: begin
        busy    = 1'b1;
        dm_wr   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, read-data capture and store-word formation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      size_q <= SZ_BYTE;
      sext_q <= 1'b0;
      dm_din <= 32'h0;
      rdata  <= 32'h0;
      err    <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        addr_q <= addr[DM_AW+1:0];
        we_q   <= we;
        size_q <= size;
        sext_q <= sext;
        if (we) dm_din <= wdata;
      end
      if (state_q == S_WAIT) begin
        if (we_q) dm_din <= merged;
        else      rdata  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: directed cases, random traffic
// against a byte-addressed reference memory, and a reset abort.
`timescale 1ns/1ps
module tb_dm_access_ctrl;
  import dm_pkg::*;

  localparam int         DM_AW      = 10;
  localparam bit         BIG_ENDIAN = 1'b0;
  localparam logic [1:0] EV_DONE    = 2'd0;
  localparam logic [1:0] EV_WR      = 2'd1;
  localparam logic [1:0] EV_ERR     = 2'd2;

  typedef struct packed {
    logic [1:0]  ev;
    logic [31:0] cyc;
    logic [31:0] data;
    logic [9:0]  wa;
    logic [1:0]  rds;
  } exp_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             req   = 1'b0;
  logic             we    = 1'b0;
  logic [1:0]       size  = 2'b00;
  logic             sext  = 1'b0;
  logic [31:0]      addr  = 32'h0;
  logic [31:0]      wdata = 32'h0;
  logic             busy, done, err, dm_wr, dm_rd;
  logic [31:0]      rdata, dm_din;
  logic [31:0]      dm_dout = 32'h0;
  logic [DM_AW-1:0] dm_addr;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  exp_t        exp_q[$];
  logic [31:0] last_rdata = 32'h0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_cnt = 0;
  logic [9:0]  rd_wa = '0;
  exp_t        m_e;
  logic        m_ok;

  dm_access_ctrl #(.DM_AW(DM_AW), .BIG_ENDIAN(BIG_ENDIAN)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .err(err), .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr),
    .dm_rd(dm_rd), .dm_dout(dm_dout)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (dm_rd) dm_dout <= mem[dm_addr];
    if (dm_wr) mem[dm_addr] <= dm_din;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] mem_byte(input logic [31:0] w, input int k);
    int p;
    p = BIG_ENDIAN ? 3 - k : k;
    return 8'((w >> (8 * p)) & 32'hFF);
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int k, input logic [7:0] v);
    logic [7:0] mb[4];
    logic [31:0] r;
    int p;
    for (int i = 0; i < 4; i++) mb[i] = mem_byte(w, i);
    mb[k] = v;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      p = BIG_ENDIAN ? 3 - i : i;
      r = r | (32'(mb[i]) << (8 * p));
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input logic hold);
    exp_t        e;
    int          acc, bi, n, lat;
    logic [9:0]  wa;
    logic        mis;
    logic [31:0] word, v, nw;
    logic [15:0] h;
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
    @(posedge clk);
    acc  = cyc;
    wa   = a[11:2];
    bi   = int'(a[1:0]);
    mis  = (sz == 2'b11) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00);
    word = ref_mem[wa];
    if (mis) begin
      e = '{ev: EV_ERR, cyc: 32'(acc + 1), data: last_rdata, wa: wa, rds: 2'd0};
      exp_q.push_back(e);
    end else if (!w) begin
      if (sz == SZ_BYTE) begin
        v = {24'h0, mem_byte(word, bi)};
        if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == SZ_HALF) begin
        h = BIG_ENDIAN ? {mem_byte(word, bi), mem_byte(word, bi + 1)}
                       : {mem_byte(word, bi + 1), mem_byte(word, bi)};
        v = {16'h0, h};
        if (sx && h[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = word;
      end
      last_rdata = v;
      e = '{ev: EV_DONE, cyc: 32'(acc + 3), data: v, wa: wa, rds: 2'd1};
      exp_q.push_back(e);
    end else begin
      if (sz == SZ_BYTE) nw = put_byte(word, bi, d[7:0]);
      else if (sz == SZ_HALF) begin
        nw = put_byte(word, bi, BIG_ENDIAN ? d[15:8] : d[7:0]);
        nw = put_byte(nw, bi + 1, BIG_ENDIAN ? d[7:0] : d[15:8]);
      end else nw = d;
      ref_mem[wa] = nw;
      lat = (sz == SZ_WORD) ? 2 : 4;
      e = '{ev: EV_WR, cyc: 32'(acc + lat - 1), data: nw, wa: wa, rds: 2'd0};
      exp_q.push_back(e);
      e = '{ev: EV_DONE, cyc: 32'(acc + lat), data: last_rdata, wa: wa,
            rds: (sz == SZ_WORD) ? 2'd0 : 2'd1};
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!hold) req = 1'b0;
    n = 0;
    while (!(mis ? err : done) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("completion_within_bound", 32'(n < 10), 32'd1);
    req = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
    end else begin
      if (dm_rd) begin
        rd_cnt++;
        rd_wa = dm_addr;
      end
      if (dm_rd || dm_wr) check("strobes_exclusive", 32'(dm_rd && dm_wr), 32'd0);
      if (dm_wr) begin
        m_ok = exp_q.size() > 0 && exp_q[0].ev == EV_WR;
        check("wr_expected", 32'(m_ok), 32'd1);
        if (m_ok) begin
          m_e = exp_q.pop_front();
          check("wr_cycle", 32'(cyc), m_e.cyc);
          check("wr_addr", 32'(dm_addr), 32'(m_e.wa));
          check("wr_data", dm_din, m_e.data);
        end
      end
      if (done) begin
        m_ok = exp_q.size() > 0 && exp_q[0].ev == EV_DONE;
        check("done_expected", 32'(m_ok), 32'd1);
        if (m_ok) begin
          m_e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), m_e.cyc);
          check("busy_at_done", 32'(busy), 32'd1);
          check("rd_count", 32'(rd_cnt), 32'(m_e.rds));
          if (m_e.rds != 0) check("rd_addr", 32'(rd_wa), 32'(m_e.wa));
          check("rdata", rdata, m_e.data);
        end
        rd_cnt = 0;
      end
      if (err) begin
        m_ok = exp_q.size() > 0 && exp_q[0].ev == EV_ERR;
        check("err_expected", 32'(m_ok), 32'd1);
        if (m_ok) begin
          m_e = exp_q.pop_front();
          check("err_cycle", 32'(cyc), m_e.cyc);
          check("err_quiet", {28'h0, busy, done, dm_rd, dm_wr}, 32'h0);
          check("err_rdata_kept", rdata, m_e.data);
          check("err_no_rd", 32'(rd_cnt), 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom();
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'h8899AABB; ref_mem[3] = 32'h8899AABB;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {27'h0, busy, done, err, dm_rd, dm_wr}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dm_addr", 32'(dm_addr), 32'h0);
    check("rst_dm_din", dm_din, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases on word 3 = 0x8899AABB
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h0000_000D, 32'h0, 1'b0);
    check("lb_value", rdata, 32'hFFFF_FFAA);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h0000_000E, 32'h0, 1'b0);
    check("lhu_value", rdata, 32'h0000_8899);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h0000_000E, 32'h0, 1'b0);
    check("lh_value", rdata, 32'hFFFF_8899);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h0000_000C, 32'h12345677, 1'b0);
    check("sb_memory", mem[3], 32'h8899_AA77);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_000C, 32'h0, 1'b0);
    check("lw_after_sb", rdata, 32'h8899_AA77);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b1);
    check("sw_memory", mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0006, 32'h0, 1'b0);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h0000_0003, 32'h5555, 1'b0);
    check("rdata_after_err", rdata, 32'h8899_AA77);
    do_req(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 1'b0);

    // Randomized traffic over a small window so RMW hits recently written words
    for (int k = 0; k < 200; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == SZ_BYTE) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == SZ_HALF) a[1] = 1'($urandom_range(0, 1));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
             1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during the WAIT cycle of a byte store
    req = 1'b1; we = 1'b1; size = SZ_BYTE; sext = 1'b0;
    addr = 32'h0000_0021; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_ctrl", {27'h0, busy, done, err, dm_rd, dm_wr}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_dm_addr", 32'(dm_addr), 32'h0);
    check("abort_dm_din", dm_din, 32'h0);
    last_rdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_wr", 32'(dm_wr), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_wr_after", 32'(dm_wr), 32'd0);
    end
    check("abort_mem_kept", mem[8], ref_mem[8]);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
